// File: rtl/sel_sequencer_if.sv
// rtl/sel_sequencer_if.sv - request/status bundle between a controller and sel_sequencer
interface sel_sequencer_if;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic       loop;
    logic [2:0] s;
    logic [2:0] idx;
    logic       valid;
    logic       busy;
    logic       done;

    modport master (
        output start, stop, mode, loop,
        input  s, idx, valid, busy, done
    );

    modport slave (
        input  start, stop, mode, loop,
        output s, idx, valid, busy, done
    );
endinterface

// File: rtl/sel_sequencer.sv
// rtl/sel_sequencer.sv - steps a 3-bit select code through eight values with a programmable dwell
module sel_sequencer #(
    parameter int STEP_CYCLES = 100
) (
    input  logic            clk,
    input  logic            rst,
    sel_sequencer_if.slave  bus
);
    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             loop_q, loop_d;
    logic [2:0]       s_q, s_d;
    logic [2:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // mode[0] walks the index backwards, mode[1] Gray-encodes the result
    function automatic logic [2:0] code_of(input logic [1:0] m, input logic [2:0] i);
        logic [2:0] g;
        g = m[0] ? ~i : i;
        code_of = m[1] ? (g ^ (g >> 1)) : g;
    endfunction

    // Next-state and next-output computation; stop beats a dwell expiry in RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        loop_d  = loop_q;
        s_d     = s_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = ST_RUN;
                    mode_d  = bus.mode;
                    loop_d  = bus.loop;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    s_d     = code_of(bus.mode, 3'd0);
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    s_d     = 3'd0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (idx_q != 3'd7) begin
                        idx_d = idx_q + 3'd1;
                        s_d   = code_of(mode_q, idx_q + 3'd1);
                    end else if (loop_q) begin
                        idx_d = 3'd0;
                        s_d   = code_of(mode_q, 3'd0);
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        idx_d   = 3'd0;
                        s_d     = 3'd0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
                s_d     = 3'd0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset returns everything to idle values
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            loop_q  <= 1'b0;
            s_q     <= 3'd0;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            loop_q  <= loop_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.s     = s_q;
    assign bus.idx   = idx_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_sel_sequencer.sv
// tb/tb_sel_sequencer.sv - self-checking bench for sel_sequencer
module tb_sel_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sel_sequencer_if if4 ();
    sel_sequencer_if if1 ();
    sel_sequencer_if if2 ();

    sel_sequencer #(.STEP_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    sel_sequencer #(.STEP_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    sel_sequencer #(.STEP_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    int         sel = 0;
    logic       st = 1'b0;
    logic       sp = 1'b0;
    logic       lp = 1'b0;
    logic [1:0] md = 2'b00;
    int         errors = 0;
    int         checks = 0;

    assign if4.start = (sel == 0) ? st : 1'b0;
    assign if4.stop  = (sel == 0) ? sp : 1'b0;
    assign if4.mode  = (sel == 0) ? md : 2'b00;
    assign if4.loop  = (sel == 0) ? lp : 1'b0;
    assign if1.start = (sel == 1) ? st : 1'b0;
    assign if1.stop  = (sel == 1) ? sp : 1'b0;
    assign if1.mode  = (sel == 1) ? md : 2'b00;
    assign if1.loop  = (sel == 1) ? lp : 1'b0;
    assign if2.start = (sel == 2) ? st : 1'b0;
    assign if2.stop  = (sel == 2) ? sp : 1'b0;
    assign if2.mode  = (sel == 2) ? md : 2'b00;
    assign if2.loop  = (sel == 2) ? lp : 1'b0;

    // observed {s, idx, valid, busy, done} of the selected instance
    logic [8:0] obs;
    always_comb begin
        case (sel)
            1:       obs = {if1.s, if1.idx, if1.valid, if1.busy, if1.done};
            2:       obs = {if2.s, if2.idx, if2.valid, if2.busy, if2.done};
            default: obs = {if4.s, if4.idx, if4.valid, if4.busy, if4.done};
        endcase
    end

    function automatic int ref_code(int m, int pos);
        int g;
        case (m)
            0: return pos;
            1: return 7 - pos;
            2: return pos ^ (pos / 2);
            default: begin
                g = 7 - pos;
                return g ^ (g / 2);
            end
        endcase
    endfunction

    // expected outputs k cycles after the accepting edge
    function automatic logic [8:0] ref_out(int k, int m, bit lpv, int sc);
        int pos;
        logic [2:0] cs;
        logic [2:0] ps;
        if (lpv || k < 8 * sc) begin
            pos = (k / sc) % 8;
            cs  = 3'(ref_code(m, pos));
            ps  = 3'(pos);
            return {cs, ps, 1'b1, 1'b1, 1'b0};
        end else if (k == 8 * sc) begin
            return 9'b000_000_001;
        end
        return 9'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sel = 0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if (obs !== 9'b0) begin
            errors++;
            $display("FAIL reset_idle actual=%h required=%h", obs, 9'b0);
        end
        md = 2'b00; lp = 1'b1; st = 1'b1;
        tick();
        st = 1'b0;
        repeat (9) tick();
        checks++;
        if (obs !== ref_out(9, 0, 1'b1, 4)) begin
            errors++;
            $display("FAIL reset_prerun actual=%h required=%h", obs, ref_out(9, 0, 1'b1, 4));
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== 9'b0) begin
                errors++;
                $display("FAIL reset_midrun cyc=%0d actual=%h required=%h", i, obs, 9'b0);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== 9'b0) begin
                errors++;
                $display("FAIL reset_after cyc=%0d actual=%h required=%h", i, obs, 9'b0);
            end
        end
    endtask

    task automatic test_binary_up();
        logic [7:0] seen;
        sel = 0;
        seen = 8'h00;
        md = 2'b00; lp = 1'b0; st = 1'b1;
        tick();
        st = 1'b0;
        for (int k = 0; k <= 8 * 4 + 1; k++) begin
            checks++;
            if (obs !== ref_out(k, 0, 1'b0, 4)) begin
                errors++;
                $display("FAIL binary_up k=%0d actual=%h required=%h", k, obs, ref_out(k, 0, 1'b0, 4));
            end
            if (obs[2]) seen[obs[8:6]] = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 8'hFF) begin
            errors++;
            $display("FAIL binary_up_coverage actual=%h required=%h", seen, 8'hFF);
        end
    endtask

    task automatic test_mode_order();
        sel = 1;
        for (int m = 0; m < 4; m++) begin
            md = 2'(m); lp = 1'b0; st = 1'b1;
            tick();
            for (int k = 0; k <= 9; k++) begin
                checks++;
                if (obs !== ref_out(k, m, 1'b0, 1)) begin
                    errors++;
                    $display("FAIL mode_order m=%0d k=%0d actual=%h required=%h", m, k, obs, ref_out(k, m, 1'b0, 1));
                end
                if (k <= 8) begin
                    md = 2'($urandom_range(0, 3));
                    lp = 1'($urandom_range(0, 1));
                    st = 1'($urandom_range(0, 1));
                end else begin
                    st = 1'b0;
                end
                tick();
            end
        end
    endtask

    task automatic test_loop_wrap();
        logic [2:0] prev;
        sel = 2;
        md = 2'b10; lp = 1'b1; st = 1'b1;
        tick();
        st = 1'b0; lp = 1'b0;
        prev = 3'd0;
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (obs !== ref_out(k, 2, 1'b1, 2)) begin
                errors++;
                $display("FAIL loop_wrap k=%0d actual=%h required=%h", k, obs, ref_out(k, 2, 1'b1, 2));
            end
            if (k > 0 && obs[8:6] !== prev) begin
                checks++;
                if ($countones(obs[8:6] ^ prev) != 1) begin
                    errors++;
                    $display("FAIL gray_step k=%0d actual=%b previous=%b required one bit change", k, obs[8:6], prev);
                end
            end
            prev = obs[8:6];
            if (k == 39) sp = 1'b1;
            tick();
        end
        sp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== 9'b0) begin
                errors++;
                $display("FAIL loop_stop cyc=%0d actual=%h required=%h", i, obs, 9'b0);
            end
            tick();
        end
    endtask

    task automatic test_simultaneous();
        int m;
        int kstop;
        sel = 0;
        st = 1'b1; sp = 1'b1; md = 2'b00;
        tick();
        st = 1'b0; sp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs !== 9'b0) begin
                errors++;
                $display("FAIL start_stop_idle cyc=%0d actual=%h required=%h", i, obs, 9'b0);
            end
            tick();
        end
        m = int'($urandom_range(0, 3));
        kstop = int'($urandom_range(0, 6)) * 4 + 3;
        md = 2'(m); lp = 1'b0; st = 1'b1;
        tick();
        st = 1'b0;
        for (int k = 0; k <= kstop; k++) begin
            checks++;
            if (obs !== ref_out(k, m, 1'b0, 4)) begin
                errors++;
                $display("FAIL stop_expiry_run k=%0d actual=%h required=%h", k, obs, ref_out(k, m, 1'b0, 4));
            end
            if (k == kstop) sp = 1'b1;
            tick();
        end
        sp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== 9'b0) begin
                errors++;
                $display("FAIL stop_expiry_idle cyc=%0d actual=%h required=%h", i, obs, 9'b0);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int m1;
        int m2;
        sel = 0;
        m1 = int'($urandom_range(0, 3));
        m2 = int'($urandom_range(0, 3));
        md = 2'(m1); lp = 1'b0; st = 1'b1;
        tick();
        st = 1'b0;
        for (int k = 0; k <= 8 * 4; k++) begin
            checks++;
            if (obs !== ref_out(k, m1, 1'b0, 4)) begin
                errors++;
                $display("FAIL b2b_first k=%0d actual=%h required=%h", k, obs, ref_out(k, m1, 1'b0, 4));
            end
            if (k < 8 * 4) tick();
        end
        st = 1'b1; md = 2'(m2);
        tick();
        checks++;
        if (obs !== 9'b0) begin
            errors++;
            $display("FAIL b2b_done_start_ignored actual=%h required=%h", obs, 9'b0);
        end
        tick();
        st = 1'b0;
        for (int k = 0; k <= 8 * 4 + 1; k++) begin
            checks++;
            if (obs !== ref_out(k, m2, 1'b0, 4)) begin
                errors++;
                $display("FAIL b2b_second k=%0d actual=%h required=%h", k, obs, ref_out(k, m2, 1'b0, 4));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_binary_up();
        test_mode_order();
        test_loop_wrap();
        test_simultaneous();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sel_sequencer.md
# sel_sequencer

Sequencer that drives the 3-bit select code `s` into the `dec_fun` decode stage, which sits directly downstream. After a `start` request it steps through all eight select values in one of four orders. Each value is held for a programmable number of cycles, so the decoder outputs `f1`/`f2`/`f3` settle and can be observed. It replaces free-running bench stimulus with a synthesizable, handshaked source and reports progress via `valid`/`busy`/`done`.

## Interface
- `STEP_CYCLES`, default 100: clock cycles each code is held. Legal range is 1..65535.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: run request; sampled only in IDLE.
- `stop` input 1: abort request; sampled in RUN (and IDLE, see below).
- `mode` input 2: step order, latched on accepted start.
  - 00: binary up.
  - 01: binary down.
  - 10: Gray up.
  - 11: Gray down.
- `loop` input 1: latched on accepted start; 1 means wrap continuously until `stop`.
- `s` output 3: select code to `dec_fun`.
- `idx` output 3: sequence position 0..7 of the current code.
- `valid` output 1: `s` holds a sequenced code.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse when a non-loop run completes.

## Operation
- **States:** IDLE, RUN, DONE.
- **Reset values:** state=IDLE, `s`=000, `idx`=000, `valid`=0, `busy`=0, `done`=0, dwell counter=0, latched `mode`=00, latched `loop`=0.
- **IDLE → RUN:**
  - Occurs on `start`=1 with `stop`=0.
  - Latch `mode` and `loop`.
  - Set `idx`=0, dwell counter=0, `valid`=1, `busy`=1.
  - Set `s` to the code for idx 0.
- **IDLE with `start`=1 and `stop`=1:** `stop` wins; remain in IDLE.
- **Code mapping from `idx`:**
  - Binary up: `s`=`idx`.
  - Binary down: `s`=~`idx` (7−`idx`).
  - Gray up: `s`=`idx`^(`idx`>>1).
  - Gray down: `s`=g^(g>>1), where g=~`idx`.
- **RUN, dwell counting:** counter increments each cycle. When counter==STEP_CYCLES−1, the counter clears and `idx` advances.
- **Advance rule:**
  - If `idx`<7: `idx`+1 and `s` updated in the same cycle.
  - If `idx`==7 and `loop`=1: `idx` wraps to 0, `s`=code(0), no gap, `valid` stays 1.
  - If `idx`==7 and `loop`=0: go to DONE.
- **RUN + `stop`=1:**
  - Next cycle state=IDLE.
  - `valid`=0, `busy`=0, `s`=000, `idx`=000, counter=0.
  - No `done` pulse.
  - `stop` takes priority over a dwell-expiry advance in the same cycle.
- **RUN + `start`:** ignored; latched `mode`/`loop` do not change mid-run.
- **DONE (exactly one cycle):**
  - `done`=1, `valid`=0, `busy`=0, `s`=000, `idx`=000.
  - `start`/`stop` ignored.
  - Next state IDLE.
- **Reset mid-run:** `rst`=1 overrides everything; all outputs take reset values on the next edge. No `done` pulse.
- **Counter width:** max(1, ceil(log2(STEP_CYCLES))). With STEP_CYCLES=1, the code changes every cycle.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Start accepted at edge N: `s`=code(0), `valid`=1, `busy`=1 visible after edge N.
- Each code is visible for exactly STEP_CYCLES cycles.
- Non-loop run:
  - `valid` high for 8×STEP_CYCLES cycles.
  - `done` high for the single cycle immediately after.
  - IDLE is reached one cycle later.
  - Earliest re-accepted `start`: cycle 8×STEP_CYCLES+1 after acceptance.
- Stop asserted at edge M in RUN: `valid`=0 and `s`=000 after edge M.
- Consecutive `s` values always differ in exactly one bit in Gray modes, including across loop wrap (100→000 up; 000→100 down).

## Test plan
- **Reset:** hold `rst` 3 cycles during RUN with STEP_CYCLES=4 → after the edge, `s`=000, `idx`=0, `valid`=0, `busy`=0, `done`=0; no `done` pulse ever seen.
- **Binary up, STEP_CYCLES=4, `loop`=0, `start` 1 cycle:**
  - `s` = 0,1,...,7, each for 4 cycles (32 cycles of `valid`).
  - Then `done`=1 for 1 cycle, `s`=000.
  - `dec_fun` sees all 8 selects.
- **Mode ordering, STEP_CYCLES=1:**
  - Binary down gives `s`=7,6,5,4,3,2,1,0.
  - Gray up gives 0,1,3,2,6,7,5,4.
  - Gray down gives 4,5,7,6,2,3,1,0.
  - `mode` toggled mid-run has no effect.
- **Loop wrap, Gray up, STEP_CYCLES=2, `loop`=1:** after 4 (at `idx`=7), `s`=0 with no `valid` gap. After 20 codes, pulse `stop` → next cycle `valid`=0, `busy`=0, `s`=000, `done` never asserted.
- **Simultaneous events:**
  - `start`+`stop` in IDLE → stays IDLE, `valid`=0.
  - `stop` on the dwell-expiry cycle → IDLE, not an advance.
  - `start` during RUN → sequence timing unchanged.
  - `start` during DONE → ignored; a `start` one cycle later is accepted.
